// File: rtl/asu_ddr5_read_dqs_detect.sv
`default_nettype none
// ============================================================================
// Module      : asu_ddr5_read_dqs_detect
// Description : DDR5 read DQS preamble hunter, burst framer, postamble checker
// Revision    : 1.0 - initial release
// ============================================================================
module asu_ddr5_read_dqs_detect (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rd_en_i,
    input  logic [1:0] dqs_bits_i,
    input  logic [7:0] pre_pattern_i,
    input  logic [1:0] pre_len_i,
    input  logic [1:0] post_pattern_i,
    input  logic       burst_chop_i,
    input  logic [7:0] timeout_i,
    output logic       data_valid_o,
    output logic       burst_start_o,
    output logic       burst_done_o,
    output logic       interamble_o,
    output logic       postamble_err_o,
    output logic       timeout_err_o,
    output logic [7:0] burst_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HUNT = 2'd1,
        S_DATA = 2'd2,
        S_POST = 2'd3
    } state_t;

    state_t     state;
    // Only the three previous pairs can ever reach a 4-cycle preamble compare.
    logic [5:0] window;
    logic [1:0] fill;
    logic [7:0] tcnt;
    logic [2:0] dcnt;

    logic [7:0] nxt_win;
    logic [7:0] pre_mask;
    logic       match;
    logic       tmo_hit;
    logic [2:0] dlen;

    always_comb begin
        nxt_win = {window, dqs_bits_i};
        case (pre_len_i)
            2'd0:    pre_mask = 8'h03;
            2'd1:    pre_mask = 8'h0F;
            2'd2:    pre_mask = 8'h3F;
            default: pre_mask = 8'hFF;
        endcase
        match   = (fill >= pre_len_i) &&
                  ((nxt_win & pre_mask) == (pre_pattern_i & pre_mask));
        tmo_hit = (timeout_i != 8'd0) &&
                  (({1'b0, tcnt} + 9'd1) == {1'b0, timeout_i});
        dlen    = burst_chop_i ? 3'd3 : 3'd7;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state           <= S_IDLE;
            window          <= 6'd0;
            fill            <= 2'd0;
            tcnt            <= 8'd0;
            dcnt            <= 3'd0;
            data_valid_o    <= 1'b0;
            burst_start_o   <= 1'b0;
            burst_done_o    <= 1'b0;
            interamble_o    <= 1'b0;
            postamble_err_o <= 1'b0;
            timeout_err_o   <= 1'b0;
            burst_cnt_o     <= 8'd0;
        end else begin
            data_valid_o    <= 1'b0;
            burst_start_o   <= 1'b0;
            burst_done_o    <= 1'b0;
            interamble_o    <= 1'b0;
            postamble_err_o <= 1'b0;
            timeout_err_o   <= 1'b0;

            if (state != S_IDLE) begin
                window <= nxt_win[5:0];
                if (fill != 2'd3) begin
                    fill <= fill + 2'd1;
                end
            end

            case (state)
                S_IDLE: begin
                    window <= 6'd0;
                    fill   <= 2'd0;
                    tcnt   <= 8'd0;
                    if (rd_en_i) begin
                        state <= S_HUNT;
                    end
                end
                S_HUNT: begin
                    if (match) begin
                        state         <= S_DATA;
                        dcnt          <= dlen;
                        data_valid_o  <= 1'b1;
                        burst_start_o <= 1'b1;
                        burst_cnt_o   <= burst_cnt_o + 8'd1;
                    end else if (!rd_en_i) begin
                        state <= S_IDLE;
                    end else if (tmo_hit) begin
                        timeout_err_o <= 1'b1;
                        state         <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                S_DATA: begin
                    data_valid_o <= 1'b1;
                    dcnt         <= dcnt - 3'd1;
                    // Leaving on the last data cycle puts POST on the postamble slot.
                    if (dcnt == 3'd1) begin
                        burst_done_o <= 1'b1;
                        state        <= S_POST;
                    end
                end
                S_POST: begin
                    if (match) begin
                        state         <= S_DATA;
                        dcnt          <= dlen;
                        data_valid_o  <= 1'b1;
                        burst_start_o <= 1'b1;
                        interamble_o  <= 1'b1;
                        burst_cnt_o   <= burst_cnt_o + 8'd1;
                    end else begin
                        postamble_err_o <= (dqs_bits_i != post_pattern_i);
                        if (rd_en_i) begin
                            state <= S_HUNT;
                            tcnt  <= 8'd0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_asu_ddr5_read_dqs_detect.sv
`default_nettype none
// Testbench for asu_ddr5_read_dqs_detect: directed scenarios plus randomized
// traffic, all checked cycle by cycle against a behavioural model.
module tb_asu_ddr5_read_dqs_detect;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rd_en;
    logic [1:0] dqs;
    logic [7:0] pre_pattern;
    logic [1:0] pre_len;
    logic [1:0] post_pattern;
    logic       burst_chop;
    logic [7:0] timeout;
    logic       data_valid, burst_start, burst_done, interamble, postamble_err, timeout_err;
    logic [7:0] burst_cnt;

    asu_ddr5_read_dqs_detect dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .rd_en_i        (rd_en),
        .dqs_bits_i     (dqs),
        .pre_pattern_i  (pre_pattern),
        .pre_len_i      (pre_len),
        .post_pattern_i (post_pattern),
        .burst_chop_i   (burst_chop),
        .timeout_i      (timeout),
        .data_valid_o   (data_valid),
        .burst_start_o  (burst_start),
        .burst_done_o   (burst_done),
        .interamble_o   (interamble),
        .postamble_err_o(postamble_err),
        .timeout_err_o  (timeout_err),
        .burst_cnt_o    (burst_cnt)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Behavioural model: mode 0 idle, 1 hunting, 2 in data, 3 postamble slot.
    int         m_mode = 0;
    int         m_left = 0;
    int         m_tcnt = 0;
    logic [1:0] hist[$];
    logic       e_dv, e_bs, e_bd, e_ia, e_pe, e_te;
    logic [7:0] e_cnt = 8'd0;

    // Per-scenario observed pulse tallies.
    int dv_n, bs_n, ia_n, pe_n, te_n, step_n, first_bs;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_match();
        int l = int'(pre_len) + 1;
        if (hist.size() < l) return 1'b0;
        for (int i = 0; i < l; i++) begin
            if (hist[hist.size() - 1 - i] != pre_pattern[2*i +: 2]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic m_start();
        e_cnt  = e_cnt + 8'd1;
        e_dv   = 1'b1;
        e_bs   = 1'b1;
        m_left = burst_chop ? 4 : 8;
        m_mode = 2;
    endtask

    task automatic m_reset();
        m_mode = 0; m_left = 0; m_tcnt = 0; hist.delete();
        e_dv = 0; e_bs = 0; e_bd = 0; e_ia = 0; e_pe = 0; e_te = 0;
        e_cnt = 8'd0;
    endtask

    task automatic model_edge();
        e_dv = 0; e_bs = 0; e_bd = 0; e_ia = 0; e_pe = 0; e_te = 0;
        if (m_mode != 0) begin
            hist.push_back(dqs);
            if (hist.size() > 4) void'(hist.pop_front());
        end
        case (m_mode)
            0: begin
                hist.delete();
                m_tcnt = 0;
                if (rd_en) m_mode = 1;
            end
            1: begin
                if (m_match()) m_start();
                else if (!rd_en) m_mode = 0;
                else if (timeout != 0 && m_tcnt + 1 == int'(timeout)) begin
                    e_te = 1; m_mode = 0;
                end else m_tcnt++;
            end
            2: begin
                m_left--;
                e_dv = 1;
                if (m_left == 1) begin e_bd = 1; m_mode = 3; end
            end
            default: begin
                if (m_match()) begin m_start(); e_ia = 1; end
                else begin
                    e_pe = (dqs != post_pattern);
                    if (rd_en) begin m_mode = 1; m_tcnt = 0; end
                    else m_mode = 0;
                end
            end
        endcase
    endtask

    task automatic check_all();
        check("data_valid",    {7'd0, data_valid},    {7'd0, e_dv});
        check("burst_start",   {7'd0, burst_start},   {7'd0, e_bs});
        check("burst_done",    {7'd0, burst_done},    {7'd0, e_bd});
        check("interamble",    {7'd0, interamble},    {7'd0, e_ia});
        check("postamble_err", {7'd0, postamble_err}, {7'd0, e_pe});
        check("timeout_err",   {7'd0, timeout_err},   {7'd0, e_te});
        check("burst_cnt",     burst_cnt,             e_cnt);
    endtask

    task automatic step(input logic rd, input logic [1:0] d);
        @(negedge clk);
        rd_en = rd;
        dqs   = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        step_n++;
        dv_n += int'(data_valid);
        bs_n += int'(burst_start);
        ia_n += int'(interamble);
        pe_n += int'(postamble_err);
        te_n += int'(timeout_err);
        if (burst_start && first_bs < 0) first_bs = step_n;
    endtask

    task automatic clear_tally();
        dv_n = 0; bs_n = 0; ia_n = 0; pe_n = 0; te_n = 0; step_n = 0; first_bs = -1;
    endtask

    task automatic go_idle();
        for (int i = 0; i < 20 && m_mode != 0; i++) step(1'b0, 2'b00);
        step(1'b0, 2'b00);
    endtask

    task automatic send_pre();
        for (int i = int'(pre_len); i >= 0; i--) step(1'b1, pre_pattern[2*i +: 2]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; rd_en = 0; dqs = 0; pre_pattern = 8'h02; pre_len = 2'd1;
        post_pattern = 2'b00; burst_chop = 0; timeout = 8'd0;
        m_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic BL16
        clear_tally();
        step(1, 2'b00);
        step(1, 2'b00); step(1, 2'b00); step(1, 2'b00); step(1, 2'b10);
        for (int i = 0; i < 8; i++) step(1, 2'($urandom));
        step(0, 2'b00);
        go_idle();
        check("bl16_dv_cycles", 8'(dv_n), 8'd8);
        check("bl16_err_count", 8'(pe_n + te_n), 8'd0);
        check("bl16_burst_cnt", burst_cnt, 8'd1);

        // BC8 with postamble error
        clear_tally();
        burst_chop = 1;
        step(1, 2'b00); step(1, 2'b00); step(1, 2'b10);
        burst_chop = 0;
        for (int i = 0; i < 3; i++) step(1, 2'b01);
        step(0, 2'b11);
        go_idle();
        check("bc8_dv_cycles", 8'(dv_n), 8'd4);
        check("bc8_post_err", 8'(pe_n), 8'd1);

        // Interamble
        clear_tally();
        pre_len = 2'd0;
        step(1, 2'b00); step(1, 2'b10);
        for (int i = 0; i < 7; i++) step(1, 2'b00);
        step(1, 2'b10);
        for (int i = 0; i < 7; i++) step(1, 2'b00);
        step(0, 2'b00);
        go_idle();
        check("ia_pulses", 8'(ia_n), 8'd1);
        check("ia_dv_cycles", 8'(dv_n), 8'd16);
        check("ia_post_err", 8'(pe_n), 8'd0);

        // Timeout
        clear_tally();
        pre_len = 2'd1; timeout = 8'd5;
        for (int i = 0; i < 6; i++) step(1, 2'b11);
        go_idle();
        check("tmo_pulses", 8'(te_n), 8'd1);
        clear_tally();
        timeout = 8'd0;
        for (int i = 0; i < 30; i++) step(1, 2'b11);
        go_idle();
        check("tmo_disabled", 8'(te_n), 8'd0);

        // Fill guard
        clear_tally();
        pre_len = 2'd3; pre_pattern = 8'h00;
        for (int i = 0; i < 12; i++) step(1, 2'b00);
        go_idle();
        check("fill_first_start", 8'(first_bs), 8'd5);

        // Reset in DATA
        pre_len = 2'd1; pre_pattern = 8'h02;
        step(1, 2'b00);
        send_pre();
        for (int i = 0; i < 2; i++) step(1, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        clear_tally();
        for (int i = 0; i < 6; i++) step(1, 2'b11);
        check("rst_no_data", 8'(dv_n), 8'd0);
        send_pre();
        for (int i = 0; i < 8; i++) step(1, 2'b11);
        go_idle();

        // Count wrap: 256 back-to-back BC8 bursts
        do_reset();
        pre_len = 2'd0; pre_pattern = 8'h02; burst_chop = 1;
        step(1, 2'b00); step(1, 2'b10);
        for (int b = 0; b < 255; b++) begin
            for (int i = 0; i < 3; i++) step(1, 2'b00);
            step(1, 2'b10);
        end
        for (int i = 0; i < 3; i++) step(1, 2'b00);
        step(0, 2'b00);
        go_idle();
        check("wrap_burst_cnt", burst_cnt, 8'd0);

        // Randomized traffic
        for (int seg = 0; seg < 30; seg++) begin
            go_idle();
            pre_len      = 2'($urandom_range(0, 3));
            pre_pattern  = 8'($urandom);
            post_pattern = 2'($urandom);
            timeout      = ($urandom % 3 == 0) ? 8'd0 : 8'($urandom_range(3, 20));
            for (int i = 0; i < 50; i++) begin
                burst_chop = 1'($urandom);
                if ($urandom % 6 == 0) send_pre();
                else step(($urandom % 16) != 0, 2'($urandom));
            end
        end
        go_idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
